fc_requant_pipe: RTL and testbench

FC_REQUANT_PIPE -- requirements
Module: fc_requant_pipe

---
 rtl/fc_requant_pipe.sv | 176 +++++++++++++++++
 tb/tb_fc_requant_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_requant_pipe.sv
// Four-stage requantization pipeline for fully-connected layer outputs:
// bias add + ReLU, fixed-point multiply, rounding shift, zero-point add + narrowing.
module fc_requant_pipe #(
    parameter bit SATURATE = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cfg_load,
    input  logic [31:0] i_quant_mult,
    input  logic [31:0] i_quant_shift,
    input  logic [7:0]  i_output_zp,
    input  logic        i_relu_en,
    input  logic [9:0]  i_neuron_count,
    input  logic        i_acc_valid,
    output logic        o_acc_ready,
    input  logic [31:0] i_acc,
    input  logic [31:0] i_bias,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [7:0]  o_out,
    output logic        o_out_last,
    output logic        o_busy,
    output logic        o_layer_done
);

    // layer configuration
    logic signed [31:0] quant_mult_q, quant_mult_d;
    logic [5:0]         total_shift_q, total_shift_d;
    logic [7:0]         output_zp_q, output_zp_d;
    logic               relu_en_q, relu_en_d;
    logic [9:0]         neuron_count_q, neuron_count_d;

    // pipeline stages
    logic               s1_valid_q, s1_valid_d;
    logic signed [31:0] s1_data_q, s1_data_d;
    logic               s2_valid_q, s2_valid_d;
    logic signed [63:0] s2_prod_q, s2_prod_d;
    logic               s3_valid_q, s3_valid_d;
    logic signed [63:0] s3_sh_q, s3_sh_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_q, out_d;

    logic [9:0]         count_q, count_d;
    logic               layer_done_q, layer_done_d;

    logic               stall, in_xfer, out_xfer, last, busy;
    logic signed [32:0] ts_full;
    logic signed [31:0] sum32, relu32;
    logic signed [63:0] prod64, rounded, sh64, zp_ext, res64;
    logic [63:0]        round64;
    logic [5:0]         shift_m1;
    logic [7:0]         out_sat;

    always_comb begin
        stall    = out_valid_q && !i_out_ready;
        in_xfer  = i_acc_valid && !stall;
        out_xfer = out_valid_q && i_out_ready;
        // neuron_count of 0 wraps to 1023 here, i.e. a 1024-output layer
        last     = out_valid_q && (count_q == neuron_count_q - 10'd1);
        busy     = s1_valid_q || s2_valid_q || s3_valid_q || out_valid_q || (count_q != 10'd0);

        ts_full  = 33'sd31 - $signed({i_quant_shift[31], i_quant_shift});

        sum32    = $signed(i_acc) + $signed(i_bias);
        relu32   = (relu_en_q && sum32[31]) ? 32'sd0 : sum32;

        prod64   = s1_data_q * quant_mult_q;

        shift_m1 = total_shift_q - 6'd1;
        round64  = 64'd1 << shift_m1;
        rounded  = s2_prod_q + $signed(round64);
        sh64     = rounded >>> total_shift_q;

        zp_ext   = {{56{output_zp_q[7]}}, output_zp_q};
        res64    = s3_sh_q + zp_ext;
        if (res64 > 64'sd127) begin
            out_sat = 8'h7F;
        end else if (res64 < -64'sd128) begin
            out_sat = 8'h80;
        end else begin
            out_sat = res64[7:0];
        end
    end

    always_comb begin
        quant_mult_d   = quant_mult_q;
        total_shift_d  = total_shift_q;
        output_zp_d    = output_zp_q;
        relu_en_d      = relu_en_q;
        neuron_count_d = neuron_count_q;
        s1_valid_d     = s1_valid_q;
        s1_data_d      = s1_data_q;
        s2_valid_d     = s2_valid_q;
        s2_prod_d      = s2_prod_q;
        s3_valid_d     = s3_valid_q;
        s3_sh_d        = s3_sh_q;
        out_valid_d    = out_valid_q;
        out_d          = out_q;
        count_d        = count_q;
        layer_done_d   = out_xfer && last;

        if (i_cfg_load && !busy) begin
            quant_mult_d   = $signed(i_quant_mult);
            output_zp_d    = i_output_zp;
            relu_en_d      = i_relu_en;
            neuron_count_d = i_neuron_count;
            if (ts_full < 33'sd1) begin
                total_shift_d = 6'd1;
            end else if (ts_full > 33'sd62) begin
                total_shift_d = 6'd62;
            end else begin
                total_shift_d = ts_full[5:0];
            end
        end

        // a single global stall freezes every stage so ordering is trivially kept
        if (!stall) begin
            s1_valid_d  = in_xfer;
            s1_data_d   = relu32;
            s2_valid_d  = s1_valid_q;
            s2_prod_d   = prod64;
            s3_valid_d  = s2_valid_q;
            s3_sh_d     = sh64;
            out_valid_d = s3_valid_q;
            out_d       = SATURATE ? out_sat : res64[7:0];
        end

        if (out_xfer) begin
            count_d = last ? 10'd0 : count_q + 10'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            quant_mult_q   <= '0;
            total_shift_q  <= 6'd31;
            output_zp_q    <= '0;
            relu_en_q      <= 1'b1;
            neuron_count_q <= '0;
            s1_valid_q     <= 1'b0;
            s1_data_q      <= '0;
            s2_valid_q     <= 1'b0;
            s2_prod_q      <= '0;
            s3_valid_q     <= 1'b0;
            s3_sh_q        <= '0;
            out_valid_q    <= 1'b0;
            out_q          <= '0;
            count_q        <= '0;
            layer_done_q   <= 1'b0;
        end else begin
            quant_mult_q   <= quant_mult_d;
            total_shift_q  <= total_shift_d;
            output_zp_q    <= output_zp_d;
            relu_en_q      <= relu_en_d;
            neuron_count_q <= neuron_count_d;
            s1_valid_q     <= s1_valid_d;
            s1_data_q      <= s1_data_d;
            s2_valid_q     <= s2_valid_d;
            s2_prod_q      <= s2_prod_d;
            s3_valid_q     <= s3_valid_d;
            s3_sh_q        <= s3_sh_d;
            out_valid_q    <= out_valid_d;
            out_q          <= out_d;
            count_q        <= count_d;
            layer_done_q   <= layer_done_d;
        end
    end

    assign o_acc_ready  = !stall;
    assign o_out_valid  = out_valid_q;
    assign o_out        = out_q;
    assign o_out_last   = last;
    assign o_busy       = busy;
    assign o_layer_done = layer_done_q;

endmodule

// File: tb/tb_fc_requant_pipe.sv
// Scoreboard bench: wrap and saturating instances share stimulus; expected results
// are queued at input transfer and checked by a monitor on each output transfer.
module tb_fc_requant_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_cfg_load = 1'b0;
    logic [31:0] i_quant_mult = '0;
    logic [31:0] i_quant_shift = '0;
    logic [7:0]  i_output_zp = '0;
    logic        i_relu_en = 1'b0;
    logic [9:0]  i_neuron_count = '0;
    logic        i_acc_valid = 1'b0;
    logic [31:0] i_acc = '0;
    logic [31:0] i_bias = '0;
    logic        i_out_ready = 1'b1;

    logic        w_ready, w_valid, w_last, w_busy, w_done;
    logic [7:0]  w_out;
    logic        s_ready, s_valid, s_last, s_busy, s_done;
    logic [7:0]  s_out;

    always #5 i_clk = ~i_clk;

    fc_requant_pipe #(.SATURATE(1'b0)) dut_wrap (
        .i_clk(i_clk), .i_rst(i_rst), .i_cfg_load(i_cfg_load),
        .i_quant_mult(i_quant_mult), .i_quant_shift(i_quant_shift),
        .i_output_zp(i_output_zp), .i_relu_en(i_relu_en), .i_neuron_count(i_neuron_count),
        .i_acc_valid(i_acc_valid), .o_acc_ready(w_ready), .i_acc(i_acc), .i_bias(i_bias),
        .o_out_valid(w_valid), .i_out_ready(i_out_ready), .o_out(w_out),
        .o_out_last(w_last), .o_busy(w_busy), .o_layer_done(w_done)
    );

    fc_requant_pipe #(.SATURATE(1'b1)) dut_sat (
        .i_clk(i_clk), .i_rst(i_rst), .i_cfg_load(i_cfg_load),
        .i_quant_mult(i_quant_mult), .i_quant_shift(i_quant_shift),
        .i_output_zp(i_output_zp), .i_relu_en(i_relu_en), .i_neuron_count(i_neuron_count),
        .i_acc_valid(i_acc_valid), .o_acc_ready(s_ready), .i_acc(i_acc), .i_bias(i_bias),
        .o_out_valid(s_valid), .i_out_ready(i_out_ready), .o_out(s_out),
        .o_out_last(s_last), .o_busy(s_busy), .o_layer_done(s_done)
    );

    typedef struct packed {
        logic [7:0] o_w;
        logic [7:0] o_s;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    logic done_exp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cfg(input logic [31:0] mult, input logic [31:0] qs, input logic [7:0] zp,
                       input logic relu, input logic [9:0] cnt);
        i_quant_mult   = mult;
        i_quant_shift  = qs;
        i_output_zp    = zp;
        i_relu_en      = relu;
        i_neuron_count = cnt;
        i_cfg_load     = 1'b1;
        cycle();
        i_cfg_load     = 1'b0;
    endtask

    // offer one input; the expectation is queued on the cycle it is accepted
    task automatic send(input logic [31:0] acc, input logic [31:0] bias,
                        input logic [7:0] ew, input logic [7:0] es, input logic el);
        int   n = 0;
        exp_t e;
        i_acc_valid = 1'b1;
        i_acc       = acc;
        i_bias      = bias;
        @(negedge i_clk);
        while (!w_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 acc=%0h", acc);
        end else begin
            e.o_w  = ew;
            e.o_s  = es;
            e.last = el;
            q.push_back(e);
            n_acc++;
        end
        @(posedge i_clk);
        #1;
        i_acc_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((w_busy || q.size() != 0) && n < 300) begin
            cycle();
            n++;
        end
        check("idle_busy", {63'd0, w_busy}, 64'd0);
        check("idle_queue", 64'(q.size()), 64'd0);
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst) begin
            done_exp = 1'b0;
        end else begin
            if (done_exp || w_done || s_done) begin
                check("layer_done", {62'd0, s_done, w_done}, {62'd0, done_exp, done_exp});
            end
            done_exp = 1'b0;
            if (w_valid && i_out_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got %0h expected none", w_out);
                end else begin
                    e = q.pop_front();
                    check("out_wrap", 64'(w_out), 64'(e.o_w));
                    check("out_sat", {55'd0, s_valid, s_out}, {55'd0, 1'b1, e.o_s});
                    check("out_last", {62'd0, s_last, w_last}, {62'd0, e.last, e.last});
                    done_exp = e.last;
                end
            end
        end
    end

    initial begin
        int lat;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // state straight out of reset
        check("rst_valid", {62'd0, s_valid, w_valid}, 64'd0);
        check("rst_busy", {62'd0, s_busy, w_busy}, 64'd0);
        check("rst_ready", {62'd0, s_ready, w_ready}, 64'd3);
        check("rst_done", {63'd0, w_done}, 64'd0);
        check("rst_out", {48'd0, s_out, w_out}, 64'd0);
        check("rst_last", {62'd0, s_last, w_last}, 64'd0);

        // mult=2^30, shift 31, zp=-128, relu on, 3-neuron layer
        cfg(32'h4000_0000, 32'd0, 8'h80, 1'b1, 10'd3);
        send(32'd1000, 32'd24, 8'h80, 8'h7F, 1'b0);
        lat = 1;
        while (!w_valid && lat < 20) begin
            cycle();
            lat++;
        end
        check("latency", 64'(lat), 64'd4);
        send(-32'sd500, 32'd0, 8'h80, 8'h80, 1'b0);
        send(32'd0, 32'd0, 8'h80, 8'h80, 1'b1);
        wait_idle();

        // relu off, single-neuron layer: -250 - 128 = -378
        cfg(32'h4000_0000, 32'd0, 8'h80, 1'b0, 10'd1);
        send(-32'sd500, 32'd0, 8'h86, 8'h80, 1'b1);
        wait_idle();

        // 10 back-to-back outputs; with mult=2^30, zp=0 an input of 2k yields k
        cfg(32'h4000_0000, 32'd0, 8'h00, 1'b0, 10'd10);
        for (int k = 0; k < 10; k++) begin
            send(32'(2 * k), 32'd0, 8'(k), 8'(k), k == 9);
        end
        check("busy_inflight", {63'd0, w_busy}, 64'd1);
        wait_idle();

        // backpressure: ready low, six offered, four fit in the pipe
        i_out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send(32'(2 * (20 + k)), 32'd0, 8'(20 + k), 8'(20 + k), 1'b0);
                end
            end
            begin
                repeat (12) cycle();
                check("stall_accepted", 64'(n_acc), 64'd4);
                check("stall_ready", {63'd0, w_ready}, 64'd0);
                check("stall_valid", {63'd0, w_valid}, 64'd1);
                i_out_ready = 1'b1;
            end
        join
        for (int k = 6; k < 10; k++) begin
            send(32'(2 * (20 + k)), 32'd0, 8'(20 + k), 8'(20 + k), k == 9);
        end
        wait_idle();

        // config load while busy must be ignored for the whole layer
        for (int k = 0; k < 10; k++) begin
            if (k == 2) begin
                cfg(32'd0, 32'd0, 8'h80, 1'b1, 10'd3);
            end
            send(32'(2 * (40 + k)), 32'd0, 8'(40 + k), 8'(40 + k), k == 9);
        end
        wait_idle();

        // reset with a full, stalled pipe discards everything in flight
        i_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(32'(2 * (60 + k)), 32'd0, 8'(60 + k), 8'(60 + k), 1'b0);
        end
        repeat (2) cycle();
        check("full_ready", {63'd0, w_ready}, 64'd0);
        i_rst = 1'b1;
        q.delete();
        cycle();
        i_rst = 1'b0;
        i_out_ready = 1'b1;
        check("rst2_valid", {62'd0, s_valid, w_valid}, 64'd0);
        check("rst2_busy", {63'd0, w_busy}, 64'd0);
        check("rst2_ready", {63'd0, w_ready}, 64'd1);

        // reset config: mult 0 and zp 0 give 0; 1024-neuron layer keeps busy high
        send(32'd1000, 32'd24, 8'h00, 8'h00, 1'b0);
        lat = 0;
        while (q.size() != 0 && lat < 50) begin
            cycle();
            lat++;
        end
        cycle();
        check("final_queue", 64'(q.size()), 64'd0);
        check("rst_cfg_busy", {63'd0, w_busy}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
